// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the two-requester multiplier sharing block.
package mult_share_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arbiter2
  import mult_share_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic [1:0] o_gnt,
  output logic       o_id
);

  always_comb begin
    o_id = ID_REQ0;
    if (i_req == 2'b11) begin
      o_id = ~i_last;
    end else if (i_req[1]) begin
      o_id = ID_REQ1;
    end
  end

  assign o_valid = |i_req;
  assign o_gnt   = o_valid ? onehot2(o_id) : 2'b00;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external 4x4 multiplier between two req/gnt requesters, with
// round-robin arbitration, done edge detection and a hung-multiplier timeout.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_timeout,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_mplr,
  output logic [WIDTH-1:0]   mul_mcand,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done
);

  state_t           r_state;
  logic             r_last;
  logic             r_opId;
  logic             r_doneQ;
  logic [CNT_W-1:0] r_cnt;

  logic       w_valid;
  logic [1:0] w_gnt;
  logic       w_id;
  logic       w_doneRise;

  rr_arbiter2 u_arb (
    .i_req  ({req1, req0}),
    .i_last (r_last),
    .o_valid(w_valid),
    .o_gnt  (w_gnt),
    .o_id   (w_id)
  );

  // A done level left high from an earlier op must not complete the next one.
  assign w_doneRise = mul_done & ~r_doneQ;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_last      <= ID_REQ1;
      r_opId      <= ID_REQ0;
      r_doneQ     <= 1'b0;
      r_cnt       <= '0;
      gnt         <= 2'b00;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_product <= '0;
      rsp_timeout <= 1'b0;
      mul_start   <= 1'b0;
      mul_mplr    <= '0;
      mul_mcand   <= '0;
    end else begin
      r_doneQ <= mul_done;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_state   <= S_ISSUE;
            busy      <= 1'b1;
            gnt       <= w_gnt;
            mul_start <= 1'b1;
            r_opId    <= w_id;
            mul_mplr  <= w_id ? a1 : a0;
            mul_mcand <= w_id ? b1 : b0;
          end
        end
        S_ISSUE: begin
          r_state   <= S_WAIT;
          gnt       <= 2'b00;
          mul_start <= 1'b0;
          r_cnt     <= '0;
        end
        S_WAIT: begin
          if (w_doneRise) begin
            r_state     <= S_DONE;
            rsp_valid   <= 1'b1;
            rsp_id      <= r_opId;
            rsp_product <= mul_product;
            rsp_timeout <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state     <= S_DONE;
            rsp_valid   <= 1'b1;
            rsp_id      <= r_opId;
            rsp_product <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          r_last    <= r_opId;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier model.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int W   = 4;
  localparam int TO  = 64;
  localparam int LAT = 3;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, rsp_valid, rsp_id, rsp_timeout, mul_start, mul_done;
  logic [2*W-1:0] rsp_product, mul_product;
  logic [W-1:0] mul_mplr, mul_mcand;

  logic [2:0]     lat;
  logic           modelDone;
  logic           hang;
  logic           forceDone;
  logic [2*W-1:0] modelProd;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[6];

  always #5 CLK = ~CLK;

  mult_share_arbiter #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(7)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_timeout(rsp_timeout),
    .mul_start(mul_start), .mul_mplr(mul_mplr), .mul_mcand(mul_mcand),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  // Multiplier model: one-cycle done pulse LAT cycles after start, unless hung.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat       <= 3'd0;
      modelDone <= 1'b0;
      modelProd <= '0;
    end else begin
      modelDone <= 1'b0;
      if (mul_start) begin
        modelProd <= mul_mplr * mul_mcand;
        lat       <= 3'(LAT);
      end else if (lat != 3'd0) begin
        lat <= lat - 3'd1;
        if (lat == 3'd1 && !hang) modelDone <= 1'b1;
      end
    end
  end

  assign mul_done    = modelDone | forceDone;
  assign mul_product = modelProd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b;
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, 32'({gnt, busy, rsp_valid, rsp_id, rsp_product, rsp_timeout,
                          mul_start, mul_mplr, mul_mcand}), 32'd0);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic waitGnt(input string name, input logic [1:0] expGnt,
                         input logic [3:0] expA, input logic [3:0] expB);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (gnt != 2'b00) seen = 1'b1;
    end
    checkOutput({name, " gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({name, " mul_start"}, 32'(mul_start), 32'd1);
    checkOutput({name, " operands"}, 32'({mul_mplr, mul_mcand}), 32'({expA, expB}));
  endtask

  task automatic waitRsp(input string name, input logic expId, input logic [7:0] expProd,
                         input logic expTo, input int expCyc, input int limit);
    int cyc   = 0;
    int extra = 0;
    bit seen  = 1'b0;
    while (!seen && cyc < limit) begin
      @(negedge CLK);
      cyc++;
      if (gnt != 2'b00) extra++;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput({name, " rsp_valid"}, 32'(seen), 32'd1);
    checkOutput({name, " rsp_id"}, 32'(rsp_id), 32'(expId));
    checkOutput({name, " rsp_product"}, 32'(rsp_product), 32'(expProd));
    checkOutput({name, " rsp_timeout"}, 32'(rsp_timeout), 32'(expTo));
    checkOutput({name, " latency"}, 32'(cyc), 32'(expCyc));
    checkOutput({name, " gnt while busy"}, 32'(extra), 32'd0);
    @(negedge CLK);
    checkOutput({name, " back to idle"}, 32'({rsp_valid, busy}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{id: 1'b0, a: 4'h4, b: 4'h9, prod: 8'h24};
    vecs[1] = '{id: 1'b1, a: 4'hF, b: 4'h1, prod: 8'h0F};
    vecs[2] = '{id: 1'b0, a: 4'h0, b: 4'hF, prod: 8'h00};
    vecs[3] = '{id: 1'b1, a: 4'hF, b: 4'hF, prod: 8'hE1};
    vecs[4] = '{id: 1'b1, a: 4'hA, b: 4'hB, prod: 8'h6E};
    vecs[5] = '{id: 1'b0, a: 4'hC, b: 4'hD, prod: 8'h9C};

    RESET = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    hang = 1'b0; forceDone = 1'b0;
    repeat (2) @(negedge CLK);
    checkAllZero("reset outputs");
    RESET = 1'b0;

    // Single-requester operations, including operand extremes.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b);
      waitGnt($sformatf("vec%0d", i), onehot2(vecs[i].id), vecs[i].a, vecs[i].b);
      req0 = 1'b0; req1 = 1'b0;
      waitRsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].prod, 1'b0, LAT + 2, 50);
    end

    // Simultaneous requests after reset: req0 first, then req1.
    doReset();
    applyStimulus(1'b0, 4'h3, 4'h5);
    applyStimulus(1'b1, 4'hF, 4'hF);
    waitGnt("tie first", 2'b01, 4'h3, 4'h5);
    req0 = 1'b0;
    waitRsp("tie first", 1'b0, 8'h0F, 1'b0, LAT + 2, 50);
    waitGnt("tie second", 2'b10, 4'hF, 4'hF);
    req1 = 1'b0;
    waitRsp("tie second", 1'b1, 8'hE1, 1'b0, LAT + 2, 50);

    // Both requests held for four operations: strict alternation.
    doReset();
    applyStimulus(1'b0, 4'h2, 4'h3);
    applyStimulus(1'b1, 4'h7, 4'h8);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) waitGnt($sformatf("fair%0d", k), 2'b01, 4'h2, 4'h3);
      else            waitGnt($sformatf("fair%0d", k), 2'b10, 4'h7, 4'h8);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      if (k % 2 == 0) waitRsp($sformatf("fair%0d", k), 1'b0, 8'h06, 1'b0, LAT + 2, 50);
      else            waitRsp($sformatf("fair%0d", k), 1'b1, 8'h38, 1'b0, LAT + 2, 50);
    end

    // Hung multiplier: timeout response after TO wait cycles.
    hang = 1'b1;
    applyStimulus(1'b0, 4'h5, 4'h5);
    waitGnt("timeout", 2'b01, 4'h5, 4'h5);
    req0 = 1'b0;
    waitRsp("timeout", 1'b0, 8'h00, 1'b1, TO + 1, 200);

    // Stale done level across ISSUE must be ignored until a fresh rising edge.
    forceDone = 1'b1;
    applyStimulus(1'b1, 4'h6, 4'h7);
    waitGnt("stale", 2'b10, 4'h6, 4'h7);
    req1 = 1'b0;
    begin
      int early = 0;
      repeat (5) begin
        @(negedge CLK);
        if (rsp_valid) early++;
      end
      checkOutput("stale no early rsp", 32'(early), 32'd0);
    end
    forceDone = 1'b0;
    @(negedge CLK);
    forceDone = 1'b1;
    waitRsp("stale", 1'b1, 8'h2A, 1'b0, 1, 20);
    forceDone = 1'b0;
    hang = 1'b0;

    // Reset during WAIT drops the op; req1 alone is granted afterwards.
    hang = 1'b1;
    applyStimulus(1'b0, 4'h8, 4'h8);
    waitGnt("midreset", 2'b01, 4'h8, 4'h8);
    req0 = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    applyStimulus(1'b1, 4'h3, 4'h4);
    #1;
    checkAllZero("midreset immediate");
    @(negedge CLK);
    checkAllZero("midreset held");
    RESET = 1'b0;
    hang = 1'b0;
    waitGnt("after reset", 2'b10, 4'h3, 4'h4);
    req1 = 1'b0;
    waitRsp("after reset", 1'b1, 8'h0C, 1'b0, LAT + 2, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
